timestamp_snapshot: RTL and testbench

- Upstream producer for the timestamp FIFO stage.
- Keeps a free-running real-time clock: 32-bit seconds plus microseconds (0..999999), advanced by a prescaler on sclk.
- On a snapshot request, captures {sec,usec} in that cycle and serializes it as a one-cycle pre_stb followed by 8 bytes: s0,s1,s2,s3,u0,u1,u2,u3, LSB first.
- Holds one pending request so back-to-back snapshots are not lost.

---
 rtl/timestamp_snapshot_pkg.sv | 36 +++
 rtl/timestamp_snapshot_if.sv | 26 ++
 rtl/timestamp_snapshot_rtc_counter.sv | 59 +++++
 rtl/timestamp_snapshot.sv | 116 +++++++++++
 tb/tb_timestamp_snapshot.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timestamp_snapshot_pkg.sv
// Shared constants, FSM state type and frame packing helpers for the timestamp snapshot block.
package timestamp_pkg;

  localparam int unsigned USEC_PER_SEC = 1000000;
  localparam int unsigned USEC_MAX     = USEC_PER_SEC - 1;
  localparam int unsigned SEC_W        = 32;
  localparam int unsigned USEC_W       = 20;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned FRAME_BYTES  = 8;
  localparam int unsigned FRAME_W      = FRAME_BYTES * BYTE_W;
  localparam int unsigned IDX_W        = $clog2(FRAME_BYTES);
  localparam int unsigned GAP_W        = 4;
  localparam int unsigned SEC_BYTE0    = 0;
  localparam int unsigned USEC_BYTE0   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_SEND,
    ST_GAP
  } state_t;

  // Byte k of the frame sits at bits [8k+7:8k]; usec is zero-extended to 32 bits.
  function automatic logic [FRAME_W-1:0] pack_frame(logic [SEC_W-1:0] s, logic [USEC_W-1:0] u);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[SEC_BYTE0*BYTE_W +: 32]  = s;
    f[USEC_BYTE0*BYTE_W +: 32] = 32'(u);
    return f;
  endfunction

  function automatic logic [BYTE_W-1:0] frame_byte(logic [FRAME_W-1:0] f, logic [IDX_W-1:0] i);
    return f[{i, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/timestamp_snapshot_if.sv
// Control, serial-frame and live-time signals of the timestamp snapshot block.
interface timestamp_snapshot_if;
  import timestamp_pkg::*;

  logic                set_stb;
  logic [SEC_W-1:0]    set_sec;
  logic [USEC_W-1:0]   set_usec;
  logic                snap;
  logic                pre_stb;
  logic [BYTE_W-1:0]   dout;
  logic                busy;
  logic                snap_lost;
  logic [SEC_W-1:0]    sec;
  logic [USEC_W-1:0]   usec;
  logic                pps;

  modport master (
    output set_stb, set_sec, set_usec, snap,
    input  pre_stb, dout, busy, snap_lost, sec, usec, pps
  );

  modport slave (
    input  set_stb, set_sec, set_usec, snap,
    output pre_stb, dout, busy, snap_lost, sec, usec, pps
  );
endinterface

// File: rtl/timestamp_snapshot_rtc_counter.sv
// Free-running seconds/microseconds clock with prescaler and load/clamp.
// TIMESTAMP_PPS_EN adds a one-cycle pps pulse on natural second rollover.
module timestamp_rtc_counter
  import timestamp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              set_stb,
  input  logic [SEC_W-1:0]  set_sec,
  input  logic [USEC_W-1:0] set_usec,
  output logic [SEC_W-1:0]  sec,
  output logic [USEC_W-1:0] usec,
  output logic              pps
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  logic [PW-1:0] presc;
  logic          tick_c;
  logic          wrap_c;

  assign tick_c = (presc == PW'(CLK_DIV - 1));
  assign wrap_c = (usec == USEC_W'(USEC_MAX));

  // A load wins over a same-cycle tick and restarts the microsecond interval.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      sec   <= '0;
      usec  <= '0;
    end else if (set_stb) begin
      presc <= '0;
      sec   <= set_sec;
      usec  <= (set_usec > USEC_W'(USEC_MAX)) ? USEC_W'(USEC_MAX) : set_usec;
    end else if (tick_c) begin
      presc <= '0;
      if (wrap_c) begin
        usec <= '0;
        sec  <= sec + SEC_W'(1);
      end else begin
        usec <= usec + USEC_W'(1);
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

`ifdef TIMESTAMP_PPS_EN
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) pps <= 1'b0;
    else     pps <= tick_c & wrap_c & ~set_stb;
  end
`else
  assign pps = 1'b0;
`endif

endmodule

// File: rtl/timestamp_snapshot.sv
// Timestamp snapshot: captures {sec,usec} on request and emits pre_stb + 8 LSB-first bytes.
// Optional pps output enabled by TIMESTAMP_PPS_EN (see timestamp_rtc_counter).
module timestamp_snapshot
  import timestamp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100,
  parameter int unsigned GAP     = 2
) (
  input logic                 sclk,
  input logic                 rst,
  timestamp_snapshot_if.slave bus
);

  state_t               state, state_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [GAP_W-1:0]     gap_cnt, gap_n;
  logic                 pend, pend_n;
  logic [FRAME_W-1:0]   pend_ts, pend_ts_n;
  logic [FRAME_W-1:0]   frame_ts, frame_n;
  logic                 lost_n;
  logic                 launch_c;
  logic [FRAME_W-1:0]   cap_c;

  timestamp_rtc_counter #(.CLK_DIV(CLK_DIV)) u_rtc (
    .sclk     (sclk),
    .rst      (rst),
    .set_stb  (bus.set_stb),
    .set_sec  (bus.set_sec),
    .set_usec (bus.set_usec),
    .sec      (bus.sec),
    .usec     (bus.usec),
    .pps      (bus.pps)
  );

  // Capture uses the registered time of the request cycle, before any load/tick lands.
  assign cap_c    = pack_frame(bus.sec, bus.usec);
  assign launch_c = (state == ST_IDLE) ||
                    ((state == ST_GAP) && (gap_cnt == GAP_W'(GAP - 1)));

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    gap_n     = gap_cnt;
    pend_n    = pend;
    pend_ts_n = pend_ts;
    frame_n   = frame_ts;
    lost_n    = 1'b0;

    case (state)
      ST_PRE: begin
        state_n = ST_SEND;
        idx_n   = '0;
      end
      ST_SEND: begin
        if (idx == IDX_W'(FRAME_BYTES - 1)) begin
          state_n = ST_GAP;
          gap_n   = '0;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP - 1)) state_n = ST_IDLE;
        else                            gap_n   = gap_cnt + GAP_W'(1);
      end
      default: ;
    endcase

    // The last gap cycle doubles as the idle launch slot, so a pending frame follows after exactly GAP cycles.
    if (launch_c) begin
      if (pend) begin
        state_n = ST_PRE;
        frame_n = pend_ts;
        pend_n  = bus.snap;
        if (bus.snap) pend_ts_n = cap_c;
      end else if (bus.snap) begin
        state_n = ST_PRE;
        frame_n = cap_c;
      end
    end else if (bus.snap) begin
      if (pend) begin
        lost_n = 1'b1;
      end else begin
        pend_n    = 1'b1;
        pend_ts_n = cap_c;
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      gap_cnt       <= '0;
      pend          <= 1'b0;
      pend_ts       <= '0;
      frame_ts      <= '0;
      bus.pre_stb   <= 1'b0;
      bus.dout      <= '0;
      bus.busy      <= 1'b0;
      bus.snap_lost <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      gap_cnt       <= gap_n;
      pend          <= pend_n;
      pend_ts       <= pend_ts_n;
      frame_ts      <= frame_n;
      bus.pre_stb   <= (state_n == ST_PRE);
      bus.dout      <= (state_n == ST_SEND) ? frame_byte(frame_n, idx_n) : '0;
      bus.busy      <= (state_n != ST_IDLE) | pend_n;
      bus.snap_lost <= lost_n;
    end
  end

endmodule

// File: tb/tb_timestamp_snapshot.sv
// Scoreboard bench for timestamp_snapshot: reference time model, frame queue, byte monitor.
module tb_timestamp_snapshot;

  localparam int unsigned CLK_DIV = 100;
  localparam int unsigned GAP     = 2;

  typedef struct {
    int          pre;
    logic [63:0] val;
  } exp_t;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   cyc  = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_pre = -100;
  int   pps_cnt = 0;
  exp_t q[$];

  logic [31:0] m_sec;
  logic [19:0] m_usec;
  int          m_pre;

  timestamp_snapshot_if bus ();

  timestamp_snapshot #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  // Reference real-time clock.
  always @(posedge sclk or posedge rst) begin
    if (rst) begin
      m_sec  <= '0;
      m_usec <= '0;
      m_pre  <= 0;
    end else if (bus.set_stb) begin
      m_sec  <= bus.set_sec;
      m_usec <= (bus.set_usec > 20'd999999) ? 20'd999999 : bus.set_usec;
      m_pre  <= 0;
    end else if (m_pre == CLK_DIV - 1) begin
      m_pre <= 0;
      if (m_usec == 20'd999999) begin
        m_usec <= '0;
        m_sec  <= m_sec + 32'd1;
      end else begin
        m_usec <= m_usec + 20'd1;
      end
    end else begin
      m_pre <= m_pre + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Queue the expected frame for a snap driven in the current cycle, unless the slot is full.
  task automatic snap_now();
    exp_t e;
    if (last_pre <= cyc + 1) begin
      e.pre = (cyc + 1 > last_pre + 9 + int'(GAP)) ? cyc + 1 : last_pre + 9 + int'(GAP);
      e.val = {12'h000, m_usec, m_sec};
      q.push_back(e);
      last_pre = e.pre;
    end
    bus.snap = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.busy) && n < 200) begin
      tick();
      n++;
    end
    check_eq("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  // Frame monitor.
  int          bidx = 8;
  logic        post = 1'b0;
  logic [63:0] cur;
  always @(negedge sclk) begin
    if (bus.pps) pps_cnt++;
    if (rst) begin
      bidx = 8;
      post = 1'b0;
    end else begin
      if (bidx < 8) begin
        check_eq($sformatf("byte%0d", bidx), 64'(bus.dout), 64'(cur[8*bidx +: 8]));
        bidx++;
        if (bidx == 8) post = 1'b1;
      end else if (post) begin
        check_eq("dout_idle_after_frame", 64'(bus.dout), 64'd0);
        post = 1'b0;
      end
      if (bus.pre_stb) begin
        check_eq("pre_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check_eq("pre_cycle", 64'(cyc), 64'(e.pre));
          cur  = e.val;
          bidx = 0;
        end
      end
    end
  end

  initial begin
    int t;
    int k;
    bus.set_stb  = 1'b0;
    bus.set_sec  = '0;
    bus.set_usec = '0;
    bus.snap     = 1'b0;

    // Reset state
    tick(); tick();
    check_eq("rst_dout", 64'(bus.dout), 64'd0);
    check_eq("rst_pre", 64'(bus.pre_stb), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_sec", 64'(bus.sec), 64'd0);
    check_eq("rst_usec", 64'(bus.usec), 64'd0);
    check_eq("rst_lost", 64'(bus.snap_lost), 64'd0);
    rst = 1'b0;
    tick();

    // Basic frame
    bus.set_stb = 1'b1; bus.set_sec = 32'h12345678; bus.set_usec = 20'h0ABCDE;
    tick();
    bus.set_stb = 1'b0;
    check_eq("set_sec", 64'(bus.sec), 64'h12345678);
    check_eq("set_usec", 64'(bus.usec), 64'h0ABCDE);
    repeat (4) tick();
    snap_now();
    tick();
    bus.snap = 1'b0;
    drain();
    check_eq("busy_idle", 64'(bus.busy), 64'd0);

    // Usec clamp
    bus.set_stb = 1'b1; bus.set_sec = 32'd1; bus.set_usec = 20'hFFFFF;
    tick();
    bus.set_stb = 1'b0;
    check_eq("clamp_usec", 64'(bus.usec), 64'd999999);

    // Second and seconds-counter rollover
    bus.set_stb = 1'b1; bus.set_sec = 32'hFFFFFFFF; bus.set_usec = 20'd999999;
    k = cyc;
    pps_cnt = 0;
    tick();
    bus.set_stb = 1'b0;
    while (cyc < k + CLK_DIV) tick();
    check_eq("pre_roll_sec", 64'(bus.sec), 64'hFFFFFFFF);
    check_eq("pre_roll_usec", 64'(bus.usec), 64'd999999);
    tick();
    check_eq("roll_sec", 64'(bus.sec), 64'd0);
    check_eq("roll_usec", 64'(bus.usec), 64'd0);
    repeat (3) tick();
`ifdef TIMESTAMP_PPS_EN
    check_eq("pps_count", 64'(pps_cnt), 64'd1);
`else
    check_eq("pps_count", 64'(pps_cnt), 64'd0);
`endif

    // Pending request: snaps at T and T+3
    t = cyc;
    snap_now(); tick(); bus.snap = 1'b0;
    tick(); tick();
    snap_now(); tick(); bus.snap = 1'b0;
    while (cyc < t + 22) tick();
    check_eq("busy_in_gap", 64'(bus.busy), 64'd1);
    tick();
    check_eq("busy_after_gap", 64'(bus.busy), 64'd0);
    drain();

    // Dropped request: snaps at T, T+2, T+4
    t = cyc;
    snap_now(); tick(); bus.snap = 1'b0;
    tick();
    snap_now(); tick(); bus.snap = 1'b0;
    tick();
    snap_now(); tick(); bus.snap = 1'b0;
    check_eq("lost_pulse", 64'(bus.snap_lost), 64'd1);
    tick();
    check_eq("lost_single", 64'(bus.snap_lost), 64'd0);
    drain();

    // Load and snap in the same cycle capture the old time
    bus.set_stb = 1'b1; bus.set_sec = 32'd5; bus.set_usec = 20'd7;
    tick();
    bus.set_sec = 32'd9; bus.set_usec = 20'd0;
    snap_now();
    tick();
    bus.set_stb = 1'b0; bus.snap = 1'b0;
    check_eq("load_sec", 64'(bus.sec), 64'd9);
    check_eq("load_usec", 64'(bus.usec), 64'd0);
    drain();

    // Reset during byte s3
    t = cyc;
    snap_now(); tick(); bus.snap = 1'b0;
    while (cyc < t + 5) tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_dout", 64'(bus.dout), 64'd0);
    check_eq("abort_pre", 64'(bus.pre_stb), 64'd0);
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_sec", 64'(bus.sec), 64'd0);
    check_eq("abort_usec", 64'(bus.usec), 64'd0);
    q.delete();
    last_pre = -100;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_eq("abort_quiet", 64'(bus.pre_stb | bus.busy), 64'd0);
    snap_now(); tick(); bus.snap = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
